// File: rtl/gearbox_pkg.sv
// rtl/gearbox_pkg.sv - shared constants and keep-mask helper for the upsizing gearbox
package gearbox_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_RATIO = 16;

  function automatic logic [MAX_RATIO-1:0] lane_mask(input int unsigned cnt);
    logic [MAX_RATIO-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_RATIO; i++) begin
      if (i <= cnt) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/gearbox_out_stage.sv
// rtl/gearbox_out_stage.sv - output word register and input-ready generation for the gearbox
module gearbox_out_stage #(
  parameter int             W        = 160,
  parameter int             M        = 4,
  parameter logic [M-1:0]   KEEP_RST = '0
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic [M-1:0] i_keep,
  input  logic         i_last,
  input  logic         i_out_tready,
  output logic         o_in_tready,
  output logic [W-1:0] o_tdata,
  output logic [M-1:0] o_tkeep,
  output logic         o_tlast,
  output logic         o_tvalid
);

  logic [W-1:0] r_data;
  logic [M-1:0] r_keep;
  logic         r_last;
  logic         r_valid;

  // A load while the held word is being consumed replaces it with no bubble.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_data  <= '0;
      r_keep  <= KEEP_RST;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
      r_valid <= 1'b1;
    end else if (r_valid && i_out_tready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_in_tready = !r_valid || i_out_tready;
  assign o_tdata     = r_data;
  assign o_tkeep     = r_keep;
  assign o_tlast     = r_last;
  assign o_tvalid    = r_valid;

endmodule

// File: rtl/gearbox_upsizing_nx.sv
// rtl/gearbox_upsizing_nx.sv - m:1 AXI-Stream upsizer; GEARBOX_UPSIZING_TLAST_EN enables tlast flush and live tkeep/tlast
module gearbox_upsizing_nx
  import gearbox_pkg::*;
#(
  parameter int n  = 5,
  parameter int m  = 4,
  parameter int nb = n * BYTE_W
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [nb-1:0]   in_tdata,
  input  logic            in_tvalid,
  output logic            in_tready,
  input  logic            in_tlast,
  output logic [m*nb-1:0] out_tdata,
  output logic [m-1:0]    out_tkeep,
  output logic            out_tlast,
  output logic            out_tvalid,
  input  logic            out_tready
);

  if (m < 2 || m > MAX_RATIO) begin : g_bad_ratio
    $error("gearbox_upsizing_nx: ratio m must be within 2..16");
  end

  localparam int CNT_W = $clog2(m);
`ifdef GEARBOX_UPSIZING_TLAST_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif
  localparam logic [m-1:0] KEEP_RST = TLAST_EN ? '0 : '1;

  logic [CNT_W-1:0]      r_cnt;
  logic [(m-1)*nb-1:0]   r_acc;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_complete;
  logic [m*nb-1:0]       w_word;
  logic [m-1:0]          w_keep;

  assign w_last     = in_tlast & TLAST_EN;
  assign w_accept   = in_tvalid & w_in_ready;
  assign w_complete = w_accept & ((r_cnt == CNT_W'(m - 1)) | w_last);
  assign w_keep     = TLAST_EN ? m'(lane_mask(32'(r_cnt))) : '1;

  // Accumulator lanes at and above cnt are always zero, so only lane cnt needs patching.
  always_comb begin
    w_word = {{nb{1'b0}}, r_acc};
    for (int i = 0; i < m; i++) begin
      if (CNT_W'(i) == r_cnt) w_word[i*nb +: nb] = in_tdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_complete) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < m - 1; i++) begin
        if (CNT_W'(i) == r_cnt) r_acc[i*nb +: nb] <= in_tdata;
      end
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  gearbox_out_stage #(
    .W        (m * nb),
    .M        (m),
    .KEEP_RST (KEEP_RST)
  ) u_out_stage (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .i_load       (w_complete),
    .i_data       (w_word),
    .i_keep       (w_keep),
    .i_last       (w_last),
    .i_out_tready (out_tready),
    .o_in_tready  (w_in_ready),
    .o_tdata      (out_tdata),
    .o_tkeep      (out_tkeep),
    .o_tlast      (out_tlast),
    .o_tvalid     (out_tvalid)
  );

  assign in_tready = w_in_ready;

endmodule

// File: tb/tb_gearbox_upsizing_nx.sv
// tb/tb_gearbox_upsizing_nx.sv - scoreboard bench for gearbox_upsizing_nx (m=4 main instance, m=2 streaming instance)
module tb_gearbox_upsizing_nx;

  localparam int N  = 5;
  localparam int M  = 4;
  localparam int NB = N * 8;
  localparam int M2 = 2;

  typedef struct packed {
    logic [M*NB-1:0] data;
    logic [M-1:0]    keep;
    logic            last;
  } word_t;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [NB-1:0]   in_tdata = '0;
  logic            in_tvalid = 1'b0;
  logic            in_tready;
  logic            in_tlast = 1'b0;
  logic [M*NB-1:0] out_tdata;
  logic [M-1:0]    out_tkeep;
  logic            out_tlast;
  logic            out_tvalid;
  logic            out_tready = 1'b1;

  logic [NB-1:0]    s2_in_tdata = '0;
  logic             s2_in_tvalid = 1'b0;
  logic             s2_in_tready;
  logic             s2_in_tlast = 1'b0;
  logic [M2*NB-1:0] s2_out_tdata;
  logic [M2-1:0]    s2_out_tkeep;
  logic             s2_out_tlast;
  logic             s2_out_tvalid;
  logic             s2_out_tready = 1'b1;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int n_exp = 0;
  int n2    = 0;

  word_t            sb[$];
  logic [M2*NB-1:0] q2[$];
  logic [M*NB-1:0]  m_data = '0;
  int               m_cnt  = 0;

  always #5 aclk = ~aclk;

  gearbox_upsizing_nx #(.n(N), .m(M)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tlast   (in_tlast),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready)
  );

  gearbox_upsizing_nx #(.n(N), .m(M2)) dut2 (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_tdata   (s2_in_tdata),
    .in_tvalid  (s2_in_tvalid),
    .in_tready  (s2_in_tready),
    .in_tlast   (s2_in_tlast),
    .out_tdata  (s2_out_tdata),
    .out_tkeep  (s2_out_tkeep),
    .out_tlast  (s2_out_tlast),
    .out_tvalid (s2_out_tvalid),
    .out_tready (s2_out_tready)
  );

  // Main-instance monitor: scoreboard pop on handshake plus stall stability checks.
  logic            p_stall = 1'b0;
  logic [M*NB-1:0] p_data;
  logic [M-1:0]    p_keep;
  logic            p_last;
  always @(negedge aclk) begin
    word_t w;
    if (!aresetn) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        total++;
        if (out_tvalid !== 1'b1 || out_tdata !== p_data || out_tkeep !== p_keep || out_tlast !== p_last) begin
          bad++;
          $display("FAIL stall_hold: got v=%b d=%h k=%b l=%b, want v=1 d=%h k=%b l=%b",
                   out_tvalid, out_tdata, out_tkeep, out_tlast, p_data, p_keep, p_last);
        end
      end
      if (out_tvalid && !out_tready) begin
        total++;
        if (in_tready !== 1'b0) begin
          bad++;
          $display("FAIL stall_in_tready: got %b want 0", in_tready);
        end
      end
      p_stall = out_tvalid && !out_tready;
      p_data  = out_tdata;
      p_keep  = out_tkeep;
      p_last  = out_tlast;
      if (out_tvalid && out_tready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got d=%h with empty scoreboard", out_tdata);
        end else begin
          w = sb.pop_front();
          if (out_tdata !== w.data || out_tkeep !== w.keep || out_tlast !== w.last) begin
            bad++;
            $display("FAIL word: got d=%h k=%b l=%b, want d=%h k=%b l=%b",
                     out_tdata, out_tkeep, out_tlast, w.data, w.keep, w.last);
          end
        end
        n_out++;
      end
    end
  end

  always @(negedge aclk) begin
    logic [M2*NB-1:0] e;
    if (aresetn && s2_out_tvalid && s2_out_tready) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL stream_unexpected: got %h", s2_out_tdata);
      end else begin
        e = q2.pop_front();
        if (s2_out_tdata !== e || s2_out_tkeep !== 2'b11 || s2_out_tlast !== 1'b0) begin
          bad++;
          $display("FAIL stream_word: got d=%h k=%b l=%b, want d=%h k=11 l=0",
                   s2_out_tdata, s2_out_tkeep, s2_out_tlast, e);
        end
      end
      n2++;
    end
  end

  task automatic send_beat(input logic [NB-1:0] d, input logic l);
    word_t w;
    logic  acc;
    int    waited;
    waited = 0;
    acc    = 1'b0;
    @(negedge aclk);
    in_tdata  = d;
    in_tlast  = l;
    in_tvalid = 1'b1;
    while (!acc) begin
      acc = in_tready;
      @(posedge aclk);
      if (!acc) begin
        @(negedge aclk);
        waited++;
        if (waited > 200) begin
          total++;
          bad++;
          $display("FAIL send_timeout: in_tready stayed 0, want 1 within 200 cycles");
          break;
        end
      end
    end
    #1 in_tvalid = 1'b0;
    if (acc) begin
      m_data[m_cnt*NB +: NB] = d;
      m_cnt++;
`ifdef GEARBOX_UPSIZING_TLAST_EN
      if (m_cnt == M || l) begin
        w.keep = M'((1 << m_cnt) - 1);
        w.last = l;
`else
      if (m_cnt == M) begin
        w.keep = '1;
        w.last = 1'b0;
`endif
        w.data = m_data;
        sb.push_back(w);
        n_exp++;
        m_data = '0;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && (sb.size() != 0 || out_tvalid); k++) @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    total++;
    if (out_tvalid !== 1'b0 || out_tdata !== '0 || out_tlast !== 1'b0 || in_tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b rdy=%b, want v=0 d=0 l=0 rdy=1",
               out_tvalid, out_tdata, out_tlast, in_tready);
    end
    total++;
`ifdef GEARBOX_UPSIZING_TLAST_EN
    if (out_tkeep !== 4'b0000) begin
      bad++;
      $display("FAIL reset_keep: got %b want 0000", out_tkeep);
    end
`else
    if (out_tkeep !== 4'b1111) begin
      bad++;
      $display("FAIL reset_keep: got %b want 1111", out_tkeep);
    end
`endif
    aresetn = 1'b1;
  endtask

  task automatic test_full_word();
    logic [M*NB-1:0] exp_d;
    exp_d = {40'h04, 40'h03, 40'h02, 40'h01};
    send_beat(40'h01, 1'b0);
    send_beat(40'h02, 1'b0);
    send_beat(40'h03, 1'b0);
    total++;
    if (out_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL full_early: out_tvalid got %b want 0 before 4th beat", out_tvalid);
    end
    send_beat(40'h04, 1'b0);
    total++;
    if (out_tvalid !== 1'b1 || out_tdata !== exp_d || out_tkeep !== 4'b1111 || out_tlast !== 1'b0) begin
      bad++;
      $display("FAIL full_latency: got v=%b d=%h k=%b l=%b, want v=1 d=%h k=1111 l=0",
               out_tvalid, out_tdata, out_tkeep, out_tlast, exp_d);
    end
    wait_drain();
  endtask

  task automatic test_tlast();
    send_beat(40'hA1, 1'b0);
    send_beat(40'hA2, 1'b1);
    total++;
`ifdef GEARBOX_UPSIZING_TLAST_EN
    if (out_tvalid !== 1'b1 || out_tkeep !== 4'b0011 || out_tlast !== 1'b1 ||
        out_tdata !== {80'h0, 40'hA2, 40'hA1}) begin
      bad++;
      $display("FAIL tlast_flush: got v=%b d=%h k=%b l=%b, want v=1 k=0011 l=1 lanes A1,A2,0,0",
               out_tvalid, out_tdata, out_tkeep, out_tlast);
    end
`else
    if (out_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL tlast_ignored: out_tvalid got %b want 0 after 2 beats", out_tvalid);
    end
    send_beat(40'hA3, 1'b0);
    send_beat(40'hA4, 1'b0);
`endif
    for (int i = 0; i < M; i++) send_beat(NB'(40'hB0 + i), 1'b0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    fork
      begin
        for (int i = 0; i < 12; i++) send_beat(NB'(40'h20 + i), 1'b0);
      end
      begin
        for (int k = 0; k < 200 && !out_tvalid; k++) @(posedge aclk);
        #2 out_tready = 1'b0;
        repeat (6) @(posedge aclk);
        #2 out_tready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_mid();
    send_beat(40'h05, 1'b0);
    send_beat(40'h06, 1'b0);
    send_beat(40'h07, 1'b0);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    total++;
    if (out_tvalid !== 1'b0 || out_tdata !== '0 || out_tlast !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got v=%b d=%h l=%b, want all 0", out_tvalid, out_tdata, out_tlast);
    end
    m_data = '0;
    m_cnt  = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < M; i++) send_beat(NB'(40'h10 + i), 1'b0);
    total++;
    if (out_tvalid !== 1'b1 || out_tdata !== {40'h13, 40'h12, 40'h11, 40'h10}) begin
      bad++;
      $display("FAIL reset_mid_word: got v=%b d=%h, want v=1 d=13,12,11,10", out_tvalid, out_tdata);
    end
    wait_drain();
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      s2_in_tdata  = NB'(i + 1);
      s2_in_tvalid = 1'b1;
      total++;
      if (s2_in_tready !== 1'b1) begin
        bad++;
        $display("FAIL stream_ready: beat %0d in_tready got %b want 1", i, s2_in_tready);
      end
      if (i % 2 == 1) q2.push_back({NB'(i + 1), NB'(i)});
    end
    @(negedge aclk);
    s2_in_tvalid = 1'b0;
    repeat (4) @(negedge aclk);
    total++;
    if (n2 != 50) begin
      bad++;
      $display("FAIL stream_count: got %0d want 50", n2);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_tlast();
    test_backpressure();
    test_reset_mid();
    test_streaming();
    total++;
    if (sb.size() != 0 || n_out != n_exp) begin
      bad++;
      $display("FAIL scoreboard_drain: got outputs=%0d pending=%0d want outputs=%0d pending=0",
               n_out, sb.size(), n_exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
